// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: requester indices,
// FSM state encoding, wait-counter width and small index helpers.
package mem_arb_pkg;

   localparam int REQ_LOAD  = 0;
   localparam int REQ_DATA  = 1;
   localparam int REQ_FETCH = 2;
   localparam int NUM_REQ   = 3;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == 2'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   // Requester that sits 'off' places after 'last' in the circular order.
   function automatic logic [1:0] rr_slot(input logic [1:0] last, input int unsigned off);
      return 2'((32'(last) + off) % NUM_REQ);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select. Fixed priority loader > data > fetch by default;
// MEM_ARB_RR_EN selects round-robin starting after the last winner.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_last,
   output logic               o_valid,
   output logic [1:0]         o_idx,
   output logic [NUM_REQ-1:0] o_onehot
);

`ifdef MEM_ARB_RR_EN
   // Walk from lowest to highest priority so the best candidate is assigned last.
   always_comb begin
      o_idx = 2'd0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (i_req[rr_slot(i_last, k)]) o_idx = rr_slot(i_last, k);
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = ^i_last;

   always_comb begin
      o_idx = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[k]) o_idx = 2'(k);
      end
   end
`endif

   assign o_valid  = |i_req;
   assign o_onehot = o_valid ? idx_to_onehot(o_idx) : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises loader / CPU data / CPU fetch accesses onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          we,
   input  logic [NUM_REQ*ADDR_W-1:0]   addr,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        busy,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [NUM_REQ-1:0]  r_sel_oh;
   logic                r_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_pick_valid;
   logic [1:0]          w_pick_idx;
   logic [NUM_REQ-1:0]  w_pick_oh;
   logic [1:0]          w_last;
   logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_sel_we;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
      assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
   end

   mem_arb_pick u_pick (
      .i_req    (req),
      .i_last   (w_last),
      .o_valid  (w_pick_valid),
      .o_idx    (w_pick_idx),
      .o_onehot (w_pick_oh)
   );

`ifdef MEM_ARB_RR_EN
   logic [1:0] r_last;

   // Pointer starts at fetch so the loader wins the first contested arbitration.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 2'(REQ_FETCH);
      end else if (r_state == ST_IDLE && w_pick_valid) begin
         r_last <= w_pick_idx;
      end
   end
   assign w_last = r_last;
`else
   assign w_last = 2'(REQ_FETCH);
`endif

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_idx == 2'(i)) begin
            w_sel_addr  = w_addr_arr[i];
            w_sel_wdata = w_wdata_arr[i];
            w_sel_we    = we[i];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_pick_valid) w_state_next = ST_ACCESS;
         ST_ACCESS: w_state_next = ST_WAIT;
         ST_WAIT:   if (r_cnt == '0) w_state_next = ST_RESP;
         ST_RESP:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sel_oh    <= '0;
         r_we        <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_sel_oh    <= w_pick_oh;
                  r_we        <= w_sel_we;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
               end
            end
            ST_ACCESS: r_cnt <= CNT_W'(WAIT_CYCLES - 1);
            ST_WAIT: begin
               // Writes leave rdata untouched; it only ever reflects the last read.
               if (r_cnt == '0) begin
                  if (!r_we) r_rdata <= mem_rdata;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt       = (r_state == ST_ACCESS) ? r_sel_oh : '0;
   assign rvalid    = (r_state == ST_RESP)   ? r_sel_oh : '0;
   assign mem_en    = (r_state == ST_ACCESS);
   assign mem_we    = (r_state == ST_ACCESS) && r_we;
   assign busy      = (r_state != ST_IDLE);
   assign rdata     = r_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances with WAIT_CYCLES 1, 3 and 4, each with
// a memory model whose read data is valid only exactly WAIT_CYCLES after mem_en.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst       [3];
   logic [2:0]      req       [3];
   logic [2:0]      we        [3];
   logic [3*AW-1:0] addr      [3];
   logic [3*DW-1:0] wdata     [3];
   logic [2:0]      gnt       [3];
   logic [2:0]      rvalid    [3];
   logic [DW-1:0]   rdata     [3];
   logic            busy      [3];
   logic            mem_en    [3];
   logic            mem_we    [3];
   logic [AW-1:0]   mem_addr  [3];
   logic [DW-1:0]   mem_wdata [3];
   logic [DW-1:0]   mem_rdata [3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
      logic [DW-1:0] mem    [1024];
      logic [DW-1:0] pipe_d [WC];
      logic          pipe_v [WC];

      mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
         .clk       (clk),
         .reset     (rst[gi]),
         .req       (req[gi]),
         .we        (we[gi]),
         .addr      (addr[gi]),
         .wdata     (wdata[gi]),
         .gnt       (gnt[gi]),
         .rvalid    (rvalid[gi]),
         .rdata     (rdata[gi]),
         .busy      (busy[gi]),
         .mem_en    (mem_en[gi]),
         .mem_we    (mem_we[gi]),
         .mem_addr  (mem_addr[gi]),
         .mem_wdata (mem_wdata[gi]),
         .mem_rdata (mem_rdata[gi])
      );

      initial begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem[5] <= 32'hDEADBEEF;
         for (int s = 0; s < WC; s++) begin
            pipe_v[s] <= 1'b0;
            pipe_d[s] <= '0;
         end
      end

      always @(posedge clk) begin
         if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
         pipe_v[0] <= mem_en[gi];
         pipe_d[0] <= mem[mem_addr[gi]];
         for (int s = 1; s < WC; s++) begin
            pipe_v[s] <= pipe_v[s-1];
            pipe_d[s] <= pipe_d[s-1];
         end
      end

      assign mem_rdata[gi] = pipe_v[WC-1] ? pipe_d[WC-1] : 32'hBAD0BAD0;
   end

   // gnt and rvalid: never together, never more than one bit each.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst[k]) begin
            check($sformatf("excl%0d", k),
                  {93'd0, (gnt[k] != 0) && (rvalid[k] != 0), !$onehot0(gnt[k]), !$onehot0(rvalid[k])},
                  96'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int k, output logic [2:0] g);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt[k] != 0) break;
      end
      g = gnt[k];
   endtask

   task automatic wait_idle(input int k);
      for (int i = 0; i < 20; i++) begin
         if (!busy[k]) break;
         tick();
      end
      check($sformatf("idle%0d", k), {95'd0, busy[k]}, 96'd0);
   endtask

   logic [2:0] g;
   logic       seen;
   int         hits [$];
   logic [2:0] exp_gnt [5];

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req[k] = '0; we[k] = '0; addr[k] = '0; wdata[k] = '0;
      end
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ctl%0d", k),
               {91'd0, gnt[k], rvalid[k], busy[k], mem_en[k], mem_we[k]}, 96'd0);
         check($sformatf("rst_dat%0d", k), {22'd0, rdata[k], mem_addr[k], mem_wdata[k]}, 96'd0);
         rst[k] = 1'b0;
      end

      // Fetch read of address 5 with one wait state.
      req[0] = 3'b100; addr[0][2*AW +: AW] = 10'd5;
      tick();
      check("t1_gnt", {93'd0, gnt[0]}, {93'd0, 3'b100});
      check("t1_mem", {84'd0, mem_en[0], mem_we[0], mem_addr[0]}, {84'd0, 1'b1, 1'b0, 10'd5});
      check("t1_busy1", {95'd0, busy[0]}, 96'd1);
      req[0] = '0;
      tick();
      check("t1_c2", {88'd0, gnt[0], rvalid[0], mem_en[0], busy[0]}, {88'd0, 3'b000, 3'b000, 1'b0, 1'b1});
      tick();
      check("t1_rvalid", {93'd0, rvalid[0]}, {93'd0, 3'b100});
      check("t1_rdata", {64'd0, rdata[0]}, {64'd0, 32'hDEADBEEF});
      check("t1_busy3", {95'd0, busy[0]}, 96'd1);
      tick();
      check("t1_done", {92'd0, busy[0], rvalid[0]}, 96'd0);

      // Data write to 1021, then fetch read back.
      req[0] = 3'b010; we[0] = 3'b010;
      addr[0][AW +: AW] = 10'd1021; wdata[0][DW +: DW] = 32'h7;
      tick();
      check("t3_gnt", {93'd0, gnt[0]}, {93'd0, 3'b010});
      check("t3_mem", {52'd0, mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]},
            {52'd0, 1'b1, 1'b1, 10'd1021, 32'h7});
      req[0] = '0; we[0] = '0;
      tick();
      check("t3_c2", {94'd0, mem_en[0], mem_we[0]}, 96'd0);
      tick();
      check("t3_ack", {93'd0, rvalid[0]}, {93'd0, 3'b010});
      check("t3_rdata_keep", {64'd0, rdata[0]}, {64'd0, 32'hDEADBEEF});
      tick();
      req[0] = 3'b100; addr[0][2*AW +: AW] = 10'd1021;
      tick();
      check("t3_fgnt", {92'd0, gnt[0], mem_we[0]}, {92'd0, 3'b100, 1'b0});
      req[0] = '0;
      tick(); tick();
      check("t3_frv", {93'd0, rvalid[0]}, {93'd0, 3'b100});
      check("t3_frdata", {64'd0, rdata[0]}, {64'd0, 32'h7});
      tick();

      // Data and fetch contending; data drops after the fourth grant.
`ifdef MEM_ARB_RR_EN
      exp_gnt = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b100};
`else
      exp_gnt = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
`endif
      req[0] = 3'b110; addr[0][AW +: AW] = 10'd5; addr[0][2*AW +: AW] = 10'd5;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(0, g);
         check($sformatf("t2_gnt%0d", n), {93'd0, g}, {93'd0, exp_gnt[n]});
         if (n == 3) req[0] = 3'b100;
         if (n == 4) req[0] = 3'b000;
      end
      wait_idle(0);

      // Loader pulse while a data read is in WAIT is forgotten.
      req[0] = 3'b010; addr[0][AW +: AW] = 10'd5;
      tick();
      check("t5_gnt", {93'd0, gnt[0]}, {93'd0, 3'b010});
      req[0] = 3'b000;
      tick();
      req[0] = 3'b001; addr[0][0 +: AW] = 10'd5;
      tick();
      req[0] = 3'b000;
      check("t5_rvalid", {93'd0, rvalid[0]}, {93'd0, 3'b010});
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | gnt[0][0];
      end
      check("t5_no_load", {95'd0, seen}, 96'd0);

      // WAIT_CYCLES=3: reset in the second WAIT cycle aborts the read.
      req[1] = 3'b001; addr[1][0 +: AW] = 10'd5;
      tick();
      check("t4_gnt", {93'd0, gnt[1]}, {93'd0, 3'b001});
      req[1] = '0;
      tick();
      tick();
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      check("t4_rst_ctl", {91'd0, gnt[1], rvalid[1], busy[1], mem_en[1], mem_we[1]}, 96'd0);
      check("t4_rst_dat", {22'd0, rdata[1], mem_addr[1], mem_wdata[1]}, 96'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | (rvalid[1] != 0);
      end
      check("t4_no_rvalid", {95'd0, seen}, 96'd0);
      req[1] = 3'b010; addr[1][AW +: AW] = 10'd5;
      wait_gnt(1, g);
      check("t4_regnt", {93'd0, g}, {93'd0, 3'b010});
      req[1] = '0;
      tick(); tick(); tick(); tick();
      check("t4_rvalid", {93'd0, rvalid[1]}, {93'd0, 3'b010});
      check("t4_rdata", {64'd0, rdata[1]}, {64'd0, 32'hDEADBEEF});

      // WAIT_CYCLES=4, fetch held: rvalid at cycles 6, 13, 20, 27.
      req[2] = 3'b100; addr[2][2*AW +: AW] = 10'd5;
      for (int c = 1; c <= 28; c++) begin
         tick();
         if (rvalid[2] != 0) hits.push_back(c);
      end
      req[2] = '0;
      check("t6_count", 96'(hits.size()), 96'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_cycle%0d", i), 96'((i < hits.size()) ? hits[i] : 0), 96'(6 + 7 * i));
      end
      check("t6_rdata", {64'd0, rdata[2]}, {64'd0, 32'hDEADBEEF});
      wait_idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
